// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - runtime-programmable glitch-free even clock divider
// Divisor changes and stops take effect only at a period wrap so oclk never shows a short phase.
module clk_div_ctrl #(
   parameter int DIV_W     = 8,
   parameter int RESET_DIV = 2
) (
   input  logic             iclk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             busy,
   output logic             cfg_err,
   output logic [DIV_W-1:0] cur_div,
   output logic             oclk,
   output logic             rise_tick,
   output logic             fall_tick
);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

   state_t           state, state_n;
   logic [DIV_W-1:0] cnt, cnt_n;
   logic [DIV_W-1:0] cur_div_n;
   logic [DIV_W-1:0] pend_div, pend_div_n;
   logic             busy_n, oclk_n, err_n;
   logic             wrap, xfer, div_ok;

   assign cfg_ready = !busy;
   assign xfer      = cfg_valid && !busy;
   assign div_ok    = !cfg_div[0] && (cfg_div != '0);
   assign wrap      = (state != IDLE) && (cnt == cur_div - ONE);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      cur_div_n  = cur_div;
      pend_div_n = pend_div;
      busy_n     = busy;
      err_n      = xfer && !div_ok;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (xfer && div_ok) cur_div_n = cfg_div;
            if (en) state_n = RUN;
         end
         default: begin
            if (wrap) begin
               cnt_n   = '0;
               state_n = en ? RUN : IDLE;
               // a pending divisor always wins; cfg_ready was low so no new transfer can coexist
               if (busy) begin
                  cur_div_n = pend_div;
                  busy_n    = 1'b0;
               end else if (xfer && div_ok) begin
                  cur_div_n = cfg_div;
               end
            end else begin
               cnt_n   = cnt + ONE;
               state_n = en ? RUN : STOPPING;
               if (xfer && div_ok) begin
                  pend_div_n = cfg_div;
                  busy_n     = 1'b1;
               end
            end
         end
      endcase
      oclk_n = (state_n != IDLE) && (cnt_n >= (cur_div_n >> 1));
   end

   always_ff @(posedge iclk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cur_div   <= RST_DIV;
         pend_div  <= '0;
         busy      <= 1'b0;
         oclk      <= 1'b0;
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cur_div   <= cur_div_n;
         pend_div  <= pend_div_n;
         busy      <= busy_n;
         oclk      <= oclk_n;
         rise_tick <= oclk_n && !oclk;
         fall_tick <= !oclk_n && oclk;
         cfg_err   <= err_n;
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl
// Directed scenarios with literal expectations plus randomized traffic against a period-level model.
module tb_clk_div_ctrl;

   logic       iclk;
   logic       rst;
   logic       en;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       busy;
   logic       cfg_err;
   logic [7:0] cur_div;
   logic       oclk;
   logic       rise_tick;
   logic       fall_tick;

   int n_pass  = 0;
   int n_total = 0;

   clk_div_ctrl #(.DIV_W(8), .RESET_DIV(2)) dut (
      .iclk      (iclk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .busy      (busy),
      .cfg_err   (cfg_err),
      .cur_div   (cur_div),
      .oclk      (oclk),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   initial begin
      iclk = 1'b0;
      forever #5 iclk = ~iclk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge iclk);
      #1;
   endtask

   // Model: mode 0 idle, 1 running, 2 running but stopping; pos = cycles into the current period.
   int m_mode, m_pos, m_div, m_pend;
   bit m_busy, m_oclk, m_rise, m_fall, m_err, m_ok;

   always @(posedge iclk) begin : model
      int mode, pos, dv, pend;
      bit bsy, o, acc, good, last;
      mode = m_mode; pos = m_pos; dv = m_div; pend = m_pend; bsy = m_busy;
      acc  = cfg_valid && !m_busy;
      good = acc && (int'(cfg_div) % 2 == 0) && (cfg_div != 0);
      if (rst) begin
         mode = 0; pos = 0; dv = 2; bsy = 0;
      end else if (m_mode == 0) begin
         pos = 0;
         if (good) dv = int'(cfg_div);
         if (en) mode = 1;
      end else begin
         last = (m_pos == m_div - 1);
         if (last) begin
            pos  = 0;
            mode = en ? 1 : 0;
            if (m_busy) begin dv = m_pend; bsy = 0; end
            else if (good) dv = int'(cfg_div);
         end else begin
            pos  = m_pos + 1;
            mode = en ? 1 : 2;
            if (good) begin pend = int'(cfg_div); bsy = 1; end
         end
      end
      o = (mode != 0) && (pos >= dv / 2);
      m_rise <= !rst && o && !m_oclk;
      m_fall <= !rst && !o && m_oclk;
      m_err  <= !rst && acc && !good;
      m_mode <= mode;
      m_pos  <= pos;
      m_div  <= dv;
      m_pend <= pend;
      m_busy <= bsy;
      m_oclk <= o;
      m_ok   <= m_ok || rst;
   end

   always @(negedge iclk) begin
      if (m_ok) begin
         chk("m_oclk", oclk, m_oclk);
         chk("m_rise", rise_tick, m_rise);
         chk("m_fall", fall_tick, m_fall);
         chk("m_cur_div", cur_div, m_div);
         chk("m_busy", busy, m_busy);
         chk("m_ready", cfg_ready, !m_busy);
         chk("m_err", cfg_err, m_err);
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
      step(2);
      rst = 1'b0;
      chk("rst_oclk", oclk, 0);
      chk("rst_cur_div", cur_div, 2);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_ticks", rise_tick + fall_tick, 0);

      // start at reset divisor 2
      en = 1'b1; step(1);
      chk("start_oclk", oclk, 0);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk("div2_oclk", oclk, k % 2);
         chk("div2_rise", rise_tick, k % 2);
         chk("div2_fall", fall_tick, 1 - k % 2);
      end
      chk("div2_cur", cur_div, 2);
      en = 1'b0; step(3);
      chk("stop_oclk", oclk, 0);

      // mid-period update 6 -> 4
      cfg_valid = 1'b1; cfg_div = 8'd6; step(1); cfg_valid = 1'b0;
      chk("idle_load", cur_div, 6);
      en = 1'b1; step(3);
      chk("d6_c2_oclk", oclk, 0);
      cfg_valid = 1'b1; cfg_div = 8'd4; step(1); cfg_valid = 1'b0;
      chk("mid_busy", busy, 1);
      chk("mid_ready", cfg_ready, 0);
      chk("mid_rise", rise_tick, 1);
      chk("mid_cur", cur_div, 6);
      step(2);
      chk("mid_c5_oclk", oclk, 1);
      chk("mid_c5_busy", busy, 1);
      step(1);
      chk("apply_cur", cur_div, 4);
      chk("apply_busy", busy, 0);
      chk("apply_fall", fall_tick, 1);
      step(1);
      chk("d4_c1_oclk", oclk, 0);
      step(1);
      chk("d4_c2_rise", rise_tick, 1);

      // update exactly on a wrap edge
      step(1);
      cfg_valid = 1'b1; cfg_div = 8'd8; step(1); cfg_valid = 1'b0;
      chk("wrap_cur", cur_div, 8);
      chk("wrap_busy", busy, 0);
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk("d8_oclk", oclk, (k % 8 >= 4) ? 1 : 0);
      end

      // invalid divisors
      cfg_valid = 1'b1; cfg_div = 8'd5; step(1); cfg_valid = 1'b0;
      chk("odd_err", cfg_err, 1);
      chk("odd_cur", cur_div, 8);
      step(1);
      chk("odd_err_clr", cfg_err, 0);
      cfg_valid = 1'b1; cfg_div = 8'd0; step(1); cfg_valid = 1'b0;
      chk("zero_err", cfg_err, 1);
      chk("zero_busy", busy, 0);
      step(1);
      chk("zero_err_clr", cfg_err, 0);
      chk("inv_oclk", oclk, 1);

      // stop with a pending divisor
      en = 1'b0; step(10);
      cfg_valid = 1'b1; cfg_div = 8'd10; step(1); cfg_valid = 1'b0;
      chk("d10_load", cur_div, 10);
      en = 1'b1; step(3);
      cfg_valid = 1'b1; cfg_div = 8'd4; step(1); cfg_valid = 1'b0;
      chk("pend_busy", busy, 1);
      step(4);
      en = 1'b0; step(1);
      chk("stopping_c8", oclk, 1);
      step(1);
      chk("stopping_c9", oclk, 1);
      chk("stopping_cur", cur_div, 10);
      step(1);
      chk("halt_oclk", oclk, 0);
      chk("halt_fall", fall_tick, 1);
      chk("halt_cur", cur_div, 4);
      chk("halt_busy", busy, 0);
      step(2);
      chk("halt_stay", oclk, 0);
      en = 1'b1; step(2);
      chk("restart_low", oclk, 0);
      step(1);
      chk("restart_rise", rise_tick, 1);

      // reset mid-operation with a pending divisor and a competing transfer
      en = 1'b0; step(6);
      cfg_valid = 1'b1; cfg_div = 8'd6; step(1); cfg_valid = 1'b0;
      en = 1'b1; step(2);
      cfg_valid = 1'b1; cfg_div = 8'd8; step(1); cfg_valid = 1'b0;
      chk("pre_rst_busy", busy, 1);
      step(2);
      rst = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd10; step(1);
      chk("mrst_oclk", oclk, 0);
      chk("mrst_cur", cur_div, 2);
      chk("mrst_busy", busy, 0);
      chk("mrst_fall", fall_tick, 0);
      rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; step(2);
      chk("mrst_idle", oclk, 0);
      chk("mrst_cur2", cur_div, 2);

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 19) == 0) en = !en;
         cfg_valid = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 9))
            0:       cfg_div = 8'd0;
            1:       cfg_div = 8'd254;
            2:       cfg_div = 8'($urandom_range(0, 255));
            default: cfg_div = 8'($urandom_range(1, 12));
         endcase
         step(1);
      end
      rst = 1'b0; cfg_valid = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
